// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: round-robin arbitration of NREQ requesters onto the single RF write port, plus a busy-register scoreboard.
// Latency: 1 cycle from handshake to rf_wen_o; backpressure is one grant per cycle, so other requesters wait via req_ready_o.
module regfile_wb_sched #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     srst_n,
    input  logic [NREQ-1:0]          req_valid_i,
    input  logic [5*NREQ-1:0]        req_addr_i,
    input  logic [DATA_W*NREQ-1:0]   req_data_i,
    output logic [NREQ-1:0]          req_ready_o,
    output logic                     rf_wen_o,
    output logic [4:0]               rf_waddr_o,
    output logic [DATA_W-1:0]        rf_wdata_o,
    input  logic                     issue_valid_i,
    input  logic [4:0]               issue_rd_i,
    output logic                     issue_ready_o,
    input  logic [4:0]               chk_raddr1_i,
    input  logic [4:0]               chk_raddr2_i,
    output logic                     stall_o,
    output logic [31:0]              busy_vec_o
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0]  last_q;
    logic [PTR_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic [NREQ-1:0]   gnt_vec;
    logic [4:0]        gnt_addr;
    logic [DATA_W-1:0] gnt_data;
    logic              wen_q;
    logic [4:0]        waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [31:0]       busy_q;
    logic [31:0]       busy_d;
    logic              set_en;

    // Rotating priority search starting just after the last granted requester.
    always_comb begin
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        gnt_vec  = '0;
        gnt_addr = '0;
        gnt_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(last_q) + 1 + k) % NREQ;
            if (!gnt_any && req_valid_i[idx]) begin
                gnt_any  = 1'b1;
                gnt_idx  = PTR_W'(idx);
                gnt_addr = req_addr_i[5*idx +: 5];
                gnt_data = req_data_i[DATA_W*idx +: DATA_W];
            end
        end
        if (!srst_n) begin
            gnt_any = 1'b0;
        end
        if (gnt_any) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    assign req_ready_o = gnt_vec;

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            last_q  <= PTR_W'(NREQ - 1);
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (gnt_any) begin
            last_q  <= gnt_idx;
            wen_q   <= (gnt_addr != 5'd0);
            waddr_q <= gnt_addr;
            wdata_q <= gnt_data;
        end else begin
            wen_q   <= 1'b0;
        end
    end

    assign rf_wen_o   = wen_q;
    assign rf_waddr_o = waddr_q;
    assign rf_wdata_o = wdata_q;

    assign issue_ready_o = ~busy_q[issue_rd_i] | (issue_rd_i == 5'd0);
    assign set_en        = issue_valid_i & issue_ready_o & (issue_rd_i != 5'd0);

    // Clear is applied before set so that set wins on a same-register collision.
    always_comb begin
        busy_d = busy_q;
        if (wen_q) begin
            busy_d[waddr_q] = 1'b0;
        end
        if (set_en) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec_o = busy_q;
    assign stall_o    = (busy_q[chk_raddr1_i] & (chk_raddr1_i != 5'd0)) |
                        (busy_q[chk_raddr2_i] & (chk_raddr2_i != 5'd0));

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched with NREQ=3: reset, round-robin, single write, x0 drop, RAW scoreboard, mid-run reset.
module tb_regfile_wb_sched;

    localparam int NREQ   = 3;
    localparam int DATA_W = 32;

    logic                   clk;
    logic                   srst_n;
    logic [NREQ-1:0]        req_valid;
    logic [5*NREQ-1:0]      req_addr;
    logic [DATA_W*NREQ-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   rf_wen;
    logic [4:0]             rf_waddr;
    logic [DATA_W-1:0]      rf_wdata;
    logic                   issue_valid;
    logic [4:0]             issue_rd;
    logic                   issue_ready;
    logic [4:0]             chk_raddr1;
    logic [4:0]             chk_raddr2;
    logic                   stall;
    logic [31:0]            busy_vec;

    int vecs;
    int miscompares;

    regfile_wb_sched #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .srst_n        (srst_n),
        .req_valid_i   (req_valid),
        .req_addr_i    (req_addr),
        .req_data_i    (req_data),
        .req_ready_o   (req_ready),
        .rf_wen_o      (rf_wen),
        .rf_waddr_o    (rf_waddr),
        .rf_wdata_o    (rf_wdata),
        .issue_valid_i (issue_valid),
        .issue_rd_i    (issue_rd),
        .issue_ready_o (issue_ready),
        .chk_raddr1_i  (chk_raddr1),
        .chk_raddr2_i  (chk_raddr2),
        .stall_o       (stall),
        .busy_vec_o    (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one active edge; inputs then change 1 time unit later, checks 1 unit after that.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic [2:0] rr_gnt [4];
        logic [4:0] rr_addr [4];
        vecs        = 0;
        miscompares = 0;
        rr_gnt[0] = 3'b001; rr_gnt[1] = 3'b010; rr_gnt[2] = 3'b100; rr_gnt[3] = 3'b001;
        rr_addr[0] = 5'd5;  rr_addr[1] = 5'd6;  rr_addr[2] = 5'd7;  rr_addr[3] = 5'd5;

        srst_n      = 1'b0;
        req_valid   = 3'b111;
        req_addr    = {5'd7, 5'd6, 5'd5};
        req_data    = {32'h0000_0007, 32'h0000_0006, 32'h0000_0005};
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        chk_raddr1  = 5'd0;
        chk_raddr2  = 5'd0;

        // Reset held two cycles with all requesters valid
        step();
        step();
        settle();
        chk("rst_req_ready", 64'(req_ready), 64'(3'b000));
        chk("rst_rf_wen", 64'(rf_wen), 64'd0);
        chk("rst_busy", 64'(busy_vec), 64'd0);
        chk("rst_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_wdata", 64'(rf_wdata), 64'd0);

        // Release: round robin 0,1,2,0 with write address lagging one cycle
        srst_n = 1'b1;
        settle();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_gnt%0d", i), 64'(req_ready), 64'(rr_gnt[i]));
            step();
            settle();
            chk($sformatf("rr_waddr%0d", i), 64'(rf_waddr), 64'(rr_addr[i]));
            chk($sformatf("rr_wen%0d", i), 64'(rf_wen), 64'd1);
        end
        chk("rr_busy", 64'(busy_vec), 64'd0);

        // Single write from requester 1
        req_valid = 3'b010;
        req_addr  = {5'd0, 5'd10, 5'd0};
        req_data  = {32'h0, 32'hDEAD_BEEF, 32'h0};
        settle();
        chk("sw_ready", 64'(req_ready), 64'(3'b010));
        step();
        req_valid = 3'b000;
        settle();
        chk("sw_wen", 64'(rf_wen), 64'd1);
        chk("sw_waddr", 64'(rf_waddr), 64'd10);
        chk("sw_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
        chk("sw_idle_ready", 64'(req_ready), 64'd0);
        step();
        settle();
        chk("sw_wen_drop", 64'(rf_wen), 64'd0);
        chk("sw_waddr_hold", 64'(rf_waddr), 64'd10);

        // Write to x0 is accepted but does not write
        req_valid = 3'b001;
        req_addr  = {5'd0, 5'd0, 5'd0};
        req_data  = {32'h0, 32'h0, 32'h0000_1234};
        settle();
        chk("x0_ready", 64'(req_ready), 64'(3'b001));
        step();
        req_valid = 3'b000;
        settle();
        chk("x0_wen", 64'(rf_wen), 64'd0);
        chk("x0_busy", 64'(busy_vec), 64'd0);
        chk("x0_wdata", 64'(rf_wdata), 64'h1234);

        // Scoreboard RAW on x8
        issue_valid = 1'b1;
        issue_rd    = 5'd8;
        settle();
        chk("raw_issue_ready0", 64'(issue_ready), 64'd1);
        step();
        settle();
        chk("raw_busy_set", 64'(busy_vec), 64'h100);
        chk("raw_issue_ready1", 64'(issue_ready), 64'd0);
        issue_valid = 1'b0;
        chk_raddr1  = 5'd8;
        settle();
        chk("raw_stall1", 64'(stall), 64'd1);
        chk_raddr1 = 5'd0;
        chk_raddr2 = 5'd8;
        settle();
        chk("raw_stall_src2", 64'(stall), 64'd1);
        chk_raddr2 = 5'd0;
        settle();
        chk("raw_x0_nostall", 64'(stall), 64'd0);
        chk_raddr1 = 5'd8;
        req_valid  = 3'b100;
        req_addr   = {5'd8, 5'd0, 5'd0};
        req_data   = {32'h0000_CAFE, 32'h0, 32'h0};
        settle();
        chk("raw_wr_ready", 64'(req_ready), 64'(3'b100));
        step();
        req_valid = 3'b000;
        settle();
        chk("raw_wen", 64'(rf_wen), 64'd1);
        chk("raw_waddr", 64'(rf_waddr), 64'd8);
        chk("raw_stall_during_wen", 64'(stall), 64'd1);
        step();
        settle();
        chk("raw_busy_clear", 64'(busy_vec), 64'd0);
        chk("raw_stall_after", 64'(stall), 64'd0);
        chk_raddr1 = 5'd0;

        // Mid-operation reset with busy 0x300 and a write pending
        issue_valid = 1'b1;
        issue_rd    = 5'd8;
        step();
        issue_rd    = 5'd9;
        step();
        issue_valid = 1'b0;
        req_valid   = 3'b010;
        req_addr    = {5'd0, 5'd9, 5'd0};
        req_data    = {32'h0, 32'h0000_0001, 32'h0};
        step();
        settle();
        chk("mr_busy", 64'(busy_vec), 64'h300);
        chk("mr_wen_pending", 64'(rf_wen), 64'd1);
        srst_n    = 1'b0;
        req_valid = 3'b111;
        req_addr  = {5'd7, 5'd6, 5'd5};
        settle();
        chk("mr_ready_in_rst", 64'(req_ready), 64'd0);
        step();
        srst_n = 1'b1;
        settle();
        chk("mr_busy_clr", 64'(busy_vec), 64'd0);
        chk("mr_wen_clr", 64'(rf_wen), 64'd0);
        chk("mr_ptr_restart", 64'(req_ready), 64'(3'b001));
        step();
        req_valid = 3'b000;
        settle();
        chk("mr_first_waddr", 64'(rf_waddr), 64'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
